// File: rtl/grid_vga_renderer_pkg.sv
// rtl/grid_vga_renderer_pkg.sv - shared VGA timing, grid geometry and colour map
package grid_vga_renderer_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int CELL_SIZE = 10;
    localparam int GRID_W    = 64;
    localparam int GRID_H    = 48;
    localparam int GRID_BITS = GRID_W * GRID_H * 2;

    localparam int COLOR_W   = 4;

    typedef enum logic [1:0] {
        CELL_BLACK = 2'b00,
        CELL_RED   = 2'b01,
        CELL_GREEN = 2'b10,
        CELL_BLUE  = 2'b11
    } cell_code_e;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = 12'h000;
    localparam rgb_t RGB_RED   = 12'hF00;
    localparam rgb_t RGB_GREEN = 12'h0F0;
    localparam rgb_t RGB_BLUE  = 12'h00F;

    function automatic rgb_t cell_to_rgb(input logic [1:0] code);
        rgb_t rgb;
        rgb = RGB_BLACK;
        case (cell_code_e'(code))
            CELL_BLACK: rgb = RGB_BLACK;
            CELL_RED:   rgb = RGB_RED;
            CELL_GREEN: rgb = RGB_GREEN;
            CELL_BLUE:  rgb = RGB_BLUE;
            default:    rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/grid_vga_renderer_if.sv
// rtl/grid_vga_renderer_if.sv - VGA video output bundle (syncs, colour, frame marker)
interface grid_vga_renderer_if;
    import grid_vga_renderer_pkg::*;

    logic               hsync;
    logic               vsync;
    logic [COLOR_W-1:0] vga_r;
    logic [COLOR_W-1:0] vga_g;
    logic [COLOR_W-1:0] vga_b;
    logic               frame_start;

    modport master (
        output hsync,
        output vsync,
        output vga_r,
        output vga_g,
        output vga_b,
        output frame_start
    );

    modport slave (
        input hsync,
        input vsync,
        input vga_r,
        input vga_g,
        input vga_b,
        input frame_start
    );

endinterface

// File: rtl/grid_vga_renderer_timing.sv
// rtl/grid_vga_renderer_timing.sv - vga_timing: pixel tick, raster counters, visible flag, raw syncs
module vga_timing
    import grid_vga_renderer_pkg::*;
#(
    parameter int H_VIS    = H_VISIBLE,
    parameter int H_FP     = H_FRONT,
    parameter int H_SYNC_W = H_SYNC,
    parameter int H_BP     = H_BACK,
    parameter int V_VIS    = V_VISIBLE,
    parameter int V_FP     = V_FRONT,
    parameter int V_SYNC_W = V_SYNC,
    parameter int V_BP     = V_BACK,
    parameter int HW       = $clog2(H_VIS + H_FP + H_SYNC_W + H_BP),
    parameter int VW       = $clog2(V_VIS + V_FP + V_SYNC_W + V_BP)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          pix_en,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          visible,
    output logic          hsync_raw,
    output logic          vsync_raw,
    output logic          line_end,
    output logic          frame_end
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC_W + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC_W + V_BP;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
    localparam logic [HW-1:0] HS_BEGIN = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC_W);

    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
    localparam logic [VW-1:0] VS_BEGIN = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC_W);

    // pix_en halves the system clock; counters only move on the edges where it is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_en <= 1'b0;
            h_cnt  <= '0;
            v_cnt  <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (line_end) begin
                    h_cnt <= '0;
                    v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);
    assign visible   = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    assign hsync_raw = ~((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
    assign vsync_raw = ~((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));

endmodule

// File: rtl/grid_vga_renderer.sv
// rtl/grid_vga_renderer.sv - renders a 2-bit-per-cell grid to VGA through a per-frame snapshot buffer
module grid_vga_renderer
    import grid_vga_renderer_pkg::*;
#(
    parameter int H_VIS     = H_VISIBLE,
    parameter int H_FP      = H_FRONT,
    parameter int H_SYNC_W  = H_SYNC,
    parameter int H_BP      = H_BACK,
    parameter int V_VIS     = V_VISIBLE,
    parameter int V_FP      = V_FRONT,
    parameter int V_SYNC_W  = V_SYNC,
    parameter int V_BP      = V_BACK,
    parameter int CELL      = CELL_SIZE,
    parameter int GRID_COLS = GRID_W,
    parameter int GRID_ROWS = GRID_H
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [GRID_COLS*GRID_ROWS*2-1:0] grid_flat,
    grid_vga_renderer_if.master              vga
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC_W + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC_W + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int SW    = (CELL > 1) ? $clog2(CELL) : 1;
    localparam int CXW   = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int CYW   = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int NBITS = GRID_COLS * GRID_ROWS * 2;
    localparam int IW    = $clog2(NBITS);

    localparam logic [SW-1:0] SUB_LAST   = SW'(CELL - 1);
    localparam logic [HW-1:0] H_LAST_VIS = HW'(H_VIS - 1);
    localparam logic [VW-1:0] V_LAST_VIS = VW'(V_VIS - 1);
    localparam logic [VW-1:0] V_SNAP     = VW'(V_VIS);

    logic          pix_en;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          visible;
    logic          hsync_raw;
    logic          vsync_raw;
    logic          line_end;
    logic          frame_end;

    vga_timing #(
        .H_VIS    (H_VIS),
        .H_FP     (H_FP),
        .H_SYNC_W (H_SYNC_W),
        .H_BP     (H_BP),
        .V_VIS    (V_VIS),
        .V_FP     (V_FP),
        .V_SYNC_W (V_SYNC_W),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .visible   (visible),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    logic [SW-1:0]  sub_x;
    logic [SW-1:0]  sub_y;
    logic [CXW-1:0] cell_x;
    logic [CYW-1:0] cell_y;

    // Cell counters always describe the pixel h_cnt/v_cnt currently point at;
    // they freeze at the last visible cell so they never run past the grid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_x  <= '0;
            sub_y  <= '0;
            cell_x <= '0;
            cell_y <= '0;
        end else if (pix_en) begin
            if (line_end) begin
                sub_x  <= '0;
                cell_x <= '0;
                if (frame_end) begin
                    sub_y  <= '0;
                    cell_y <= '0;
                end else if (v_cnt < V_LAST_VIS) begin
                    if (sub_y == SUB_LAST) begin
                        sub_y  <= '0;
                        cell_y <= cell_y + 1'b1;
                    end else begin
                        sub_y <= sub_y + 1'b1;
                    end
                end
            end else if (visible && (h_cnt < H_LAST_VIS)) begin
                if (sub_x == SUB_LAST) begin
                    sub_x  <= '0;
                    cell_x <= cell_x + 1'b1;
                end else begin
                    sub_x <= sub_x + 1'b1;
                end
            end
        end
    end

    logic [NBITS-1:0] frame_buf;

    // Snapshot at the first vertical-blanking line so the next frame is tear-free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_buf <= '0;
        end else if (pix_en && (h_cnt == '0) && (v_cnt == V_SNAP)) begin
            frame_buf <= grid_flat;
        end
    end

    logic [IW-1:0] cell_idx;
    logic [1:0]    cell_code;
    rgb_t          pix_rgb;

    assign cell_idx  = IW'((int'(cell_y) * GRID_COLS + int'(cell_x)) * 2);
    assign cell_code = frame_buf[cell_idx +: 2];
    assign pix_rgb   = visible ? cell_to_rgb(cell_code) : RGB_BLACK;

    logic hsync_q;
    logic vsync_q;
    rgb_t rgb_q;
    logic frame_start_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= RGB_BLACK;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_en && frame_end;
            if (pix_en) begin
                hsync_q <= hsync_raw;
                vsync_q <= vsync_raw;
                rgb_q   <= pix_rgb;
            end
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.vga_r       = rgb_q.r;
    assign vga.vga_g       = rgb_q.g;
    assign vga.vga_b       = rgb_q.b;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_grid_vga_renderer.sv
// tb/tb_grid_vga_renderer.sv - self-checking bench for grid_vga_renderer on a reduced raster
module tb_grid_vga_renderer;

    localparam int CELL = 3;
    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int HV = 12, HF = 2, HS = 4, HB = 2;
    localparam int VV = 9,  VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int NB = COLS * ROWS * 2;
    localparam int NPROBE = 15;

    typedef struct {
        int         f;
        int         x;
        int         y;
        logic       hs;
        logic       vs;
        logic [11:0] rgb;
        logic       fs;
    } pix_t;

    typedef struct {
        logic [NB-1:0] grid;
        int            f;
        int            x;
        int            y;
        logic [11:0]   rgb;
    } probe_t;

    logic          clk;
    logic          reset;
    logic [NB-1:0] grid_flat;
    logic          chk_en;

    grid_vga_renderer_if vga_bus ();

    grid_vga_renderer #(
        .H_VIS (HV), .H_FP (HF), .H_SYNC_W (HS), .H_BP (HB),
        .V_VIS (VV), .V_FP (VF), .V_SYNC_W (VS), .V_BP (VB),
        .CELL (CELL), .GRID_COLS (COLS), .GRID_ROWS (ROWS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .grid_flat (grid_flat),
        .vga       (vga_bus)
    );

    logic [11:0] dut_rgb;
    assign dut_rgb = {vga_bus.vga_r, vga_bus.vga_g, vga_bus.vga_b};

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int fs_cnt = 0;

    pix_t exp_q[$];
    int   cur_x, cur_y, cur_f;
    bit   cur_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic pix_t expect_px(input int x, input int y, input int f, input logic [NB-1:0] b);
        pix_t p;
        int   idx;
        p.f   = f;
        p.x   = x;
        p.y   = y;
        p.hs  = !(x >= HV + HF && x < HV + HF + HS);
        p.vs  = !(y >= VV + VF && y < VV + VF + VS);
        p.rgb = 12'h000;
        p.fs  = 1'b0;
        if (x < HV && y < VV) begin
            idx = ((y / CELL) * COLS + (x / CELL)) * 2;
            case (b[idx +: 2])
                2'b01:   p.rgb = 12'hF00;
                2'b10:   p.rgb = 12'h0F0;
                2'b11:   p.rgb = 12'h00F;
                default: p.rgb = 12'h000;
            endcase
        end
        return p;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Raster model: one expected pixel record per pixel tick, based on its own snapshot copy
    initial begin
        bit            m_pix;
        int            m_x, m_y, m_f;
        logic [NB-1:0] m_buf;
        pix_t          e;
        m_pix = 0; m_x = 0; m_y = 0; m_f = 1; m_buf = '0; cur_valid = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_pix = 0; m_x = 0; m_y = 0; m_f = 1; m_buf = '0; cur_valid = 0;
                exp_q.delete();
            end else begin
                if (m_pix) begin
                    e = expect_px(m_x, m_y, m_f, m_buf);
                    e.fs = (m_x == HT - 1 && m_y == VT - 1);
                    exp_q.push_back(e);
                    cur_x = m_x; cur_y = m_y; cur_f = m_f; cur_valid = 1;
                    if (m_x == 0 && m_y == VV) m_buf = grid_flat;
                    if (m_x == HT - 1) begin
                        m_x = 0;
                        if (m_y == VT - 1) begin
                            m_y = 0;
                            m_f++;
                        end else begin
                            m_y++;
                        end
                    end else begin
                        m_x++;
                    end
                end
                m_pix = !m_pix;
            end
        end
    end

    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (reset) begin
                    check("reset_out", 32'({vga_bus.hsync, vga_bus.vsync, dut_rgb, vga_bus.frame_start}),
                          32'({1'b1, 1'b1, 12'h000, 1'b0}));
                end else if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("pix f%0d x%0d y%0d {hs,vs,rgb,fs}", e.f, e.x, e.y),
                          32'({vga_bus.hsync, vga_bus.vsync, dut_rgb, vga_bus.frame_start}),
                          32'({e.hs, e.vs, e.rgb, e.fs}));
                end else begin
                    check("frame_start_idle", 32'(vga_bus.frame_start), 32'd0);
                end
                if (!reset && vga_bus.frame_start) fs_cnt++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset(input logic [NB-1:0] g);
        @(negedge clk);
        #2;
        reset = 1'b1;
        grid_flat = g;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic wait_pixel(input int f, input int x, input int y, output bit ok);
        ok = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (cur_valid && cur_f == f && cur_x == x && cur_y == y) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_sync(input bit is_v, input logic lvl, output int t, output bit ok);
        ok = 0;
        t  = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if ((is_v ? vga_bus.vsync : vga_bus.hsync) == lvl) begin
                ok = 1;
                t  = cyc;
                break;
            end
        end
    endtask

    task automatic measure(input bit is_v, input int exp_low, input int exp_period, input string tag);
        int t0, t1, t2, tx;
        bit ok0, ok1, ok2, okx;
        wait_sync(is_v, 1'b1, tx, okx);
        wait_sync(is_v, 1'b0, t0, ok0);
        wait_sync(is_v, 1'b1, t1, ok1);
        wait_sync(is_v, 1'b0, t2, ok2);
        check({tag, "_found"}, 32'(okx & ok0 & ok1 & ok2), 32'd1);
        check({tag, "_low_clk"}, 32'(t1 - t0), 32'(exp_low));
        check({tag, "_period_clk"}, 32'(t2 - t0), 32'(exp_period));
    endtask

    probe_t        tbl[NPROBE];
    logic [NB-1:0] g_all00, g_all10, g_all11, g_red, g_chk;

    initial begin
        bit ok;
        reset = 1'b1;
        grid_flat = '0;
        chk_en = 1'b0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;

        g_all00 = '0;
        g_all10 = {(COLS * ROWS){2'b10}};
        g_all11 = {(COLS * ROWS){2'b11}};
        g_red   = '0;
        g_red[((ROWS - 1) * COLS + (COLS - 1)) * 2 +: 2] = 2'b01;
        for (int cy = 0; cy < ROWS; cy++)
            for (int cx = 0; cx < COLS; cx++)
                g_chk[(cy * COLS + cx) * 2 +: 2] = ((cx + cy) % 2 == 0) ? 2'b10 : 2'b11;

        tbl[0]  = '{g_all10, 1, 0,  0, 12'h000};
        tbl[1]  = '{g_all10, 1, 11, 8, 12'h000};
        tbl[2]  = '{g_all10, 2, 0,  0, 12'h0F0};
        tbl[3]  = '{g_all10, 2, 12, 0, 12'h000};
        tbl[4]  = '{g_all10, 2, 11, 8, 12'h0F0};
        tbl[5]  = '{g_all10, 2, 0,  9, 12'h000};
        tbl[6]  = '{g_red,   2, 0,  0, 12'h000};
        tbl[7]  = '{g_red,   2, 9,  5, 12'h000};
        tbl[8]  = '{g_red,   2, 8,  6, 12'h000};
        tbl[9]  = '{g_red,   2, 9,  6, 12'hF00};
        tbl[10] = '{g_red,   2, 11, 8, 12'hF00};
        tbl[11] = '{g_chk,   2, 2,  0, 12'h0F0};
        tbl[12] = '{g_chk,   2, 3,  0, 12'h00F};
        tbl[13] = '{g_chk,   2, 0,  3, 12'h00F};
        tbl[14] = '{g_chk,   2, 3,  3, 12'h0F0};

        for (int i = 0; i < NPROBE; i++) begin
            if (i == 0 || tbl[i].grid != tbl[i - 1].grid) do_reset(tbl[i].grid);
            wait_pixel(tbl[i].f, tbl[i].x, tbl[i].y, ok);
            check($sformatf("probe%0d_reached", i), 32'(ok), 32'd1);
            check($sformatf("probe%0d f%0d (%0d,%0d) rgb", i, tbl[i].f, tbl[i].x, tbl[i].y),
                  32'(dut_rgb), 32'(tbl[i].rgb));
        end

        // Sync pulse widths and periods in system clocks
        do_reset(g_all10);
        measure(1'b0, 2 * HS, 2 * HT, "hsync");
        measure(1'b1, 2 * HT * VS, 2 * HT * VT, "vsync");

        // Grid change in the middle of a displayed frame
        do_reset(g_all00);
        wait_pixel(2, 0, 4, ok);
        check("chg_reached", 32'(ok), 32'd1);
        grid_flat = g_all11;
        wait_pixel(2, 11, 8, ok);
        check("chg_cur_frame_black", 32'(dut_rgb), 32'h000);
        wait_pixel(3, 0, 0, ok);
        check("chg_next_first_blue", 32'(dut_rgb), 32'h00F);
        wait_pixel(3, 11, 8, ok);
        check("chg_next_last_blue", 32'(dut_rgb), 32'h00F);

        // Reset asserted inside the visible area
        do_reset(g_all10);
        wait_pixel(2, 3, 5, ok);
        check("rst_reached", 32'(ok), 32'd1);
        check("pre_rst_rgb", 32'(dut_rgb), 32'h0F0);
        #2;
        reset = 1'b1;
        fs_cnt = 0;
        #1;
        check("rst_async_outputs", 32'({vga_bus.hsync, vga_bus.vsync, dut_rgb, vga_bus.frame_start}),
              32'({1'b1, 1'b1, 12'h000, 1'b0}));
        @(negedge clk);
        #2;
        reset = 1'b0;
        wait_pixel(1, 3, 5, ok);
        check("restart_buf_black", 32'(dut_rgb), 32'h000);
        wait_pixel(1, HT - 2, VT - 1, ok);
        check("restart_no_frame_start", 32'(fs_cnt), 32'd0);
        wait_pixel(2, 0, 0, ok);
        check("restart_one_frame_start", 32'(fs_cnt), 32'd1);

        // Reset asserted while both syncs are active
        wait_pixel(2, HV + HF + 1, VV + VF, ok);
        check("sync_pre_rst", 32'({vga_bus.hsync, vga_bus.vsync}), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("sync_rst_release", 32'({vga_bus.hsync, vga_bus.vsync}), 32'd3);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
